// File: rtl/fpu_unpack_pkg.sv
// Shared types and constants for the FPU exponent-unpack scheduler.
package fpu_unpack_pkg;

  localparam int FP_W  = 64;
  localparam int EXP_W = 11;
  localparam int NREQ  = 2;

  localparam logic [EXP_W-1:0] BIAS_DP       = 11'd1023;
  localparam logic [EXP_W-1:0] BIAS_SP       = 11'd127;
  // Zero/denormal operands report this fixed exponent code; consumers key off e_z.
  localparam logic [EXP_W-1:0] EXP_ZERO_CODE = 11'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UNPK_A = 2'd1,
    UNPK_B = 2'd2,
    OUT    = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic             e_z;
    logic             e_inf;
  } unpk_res_t;

endpackage

// File: rtl/exponent.sv
// Exponent unpack unit: sign, unbiased exponent and zero/all-ones flags of one
// operand. Input is {operand, db}; single precision lives in operand[63:32].
module exponent
  import fpu_unpack_pkg::*;
(
  input  logic [FP_W:0] op_i,
  output unpk_res_t     res_o
);

  logic [FP_W-1:0]  f;
  logic             db;
  logic [EXP_W-1:0] e_dp;
  logic [7:0]       e_sp;
  logic             unused_mant;

  assign f           = op_i[FP_W:1];
  assign db          = op_i[0];
  assign e_dp        = f[62:52];
  assign e_sp        = f[62:55];
  assign unused_mant = ^f[51:0];

  // Field extraction and rebias for the selected precision.
  always_comb begin
    res_o   = '0;
    res_o.s = f[FP_W-1];
    if (db) begin
      res_o.e_z   = (e_dp == '0);
      res_o.e_inf = &e_dp;
      res_o.e     = e_dp - BIAS_DP;
    end else begin
      res_o.e_z   = (e_sp == '0);
      res_o.e_inf = &e_sp;
      res_o.e     = {3'b000, e_sp} - BIAS_SP;
    end
    if (res_o.e_z) begin
      res_o.e = EXP_ZERO_CODE;
    end
  end

endmodule

// File: rtl/unpack_rr_arb.sv
// Two-way round-robin grant; ptr_i names the requester preferred on a tie.
module unpack_rr_arb (
  input  logic       en_i,
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o,
  output logic       idx_o
);

  // Single requester wins outright; a tie goes to the pointer.
  always_comb begin
    gnt_o = 2'b00;
    idx_o = 1'b0;
    if (en_i) begin
      case (req_i)
        2'b01: begin
          gnt_o = 2'b01;
          idx_o = 1'b0;
        end
        2'b10: begin
          gnt_o = 2'b10;
          idx_o = 1'b1;
        end
        2'b11: begin
          gnt_o = ptr_i ? 2'b10 : 2'b01;
          idx_o = ptr_i;
        end
        default: begin
          gnt_o = 2'b00;
          idx_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fpu_unpack_sched.sv
// Scheduler sharing one exponent-unpack unit between two operand-pair issuers.
// Optional special-operand counter enabled by macro FPU_UNPACK_STATS_EN.
//
//   state  | meaning
//   IDLE   | no pair in flight; grant window open
//   UNPK_A | shared unit unpacks operand A
//   UNPK_B | shared unit unpacks operand B
//   OUT    | result bundle valid; grant window open on handshake
module fpu_unpack_sched
  import fpu_unpack_pkg::*;
#(
  parameter int   STAT_W   = 16,
  parameter logic RR_RESET = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*FP_W-1:0] req_fa,
  input  logic [NREQ*FP_W-1:0] req_fb,
  input  logic [NREQ-1:0]      req_db,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_tag,
  output logic                 out_db,
  output logic                 out_sa,
  output logic                 out_sb,
  output logic [EXP_W-1:0]     out_ea,
  output logic [EXP_W-1:0]     out_eb,
  output logic                 out_ea_z,
  output logic                 out_eb_z,
  output logic                 out_ea_inf,
  output logic                 out_eb_inf
`ifdef FPU_UNPACK_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [STAT_W-1:0]    stat_special
`endif
);

  sched_state_e    state_q, state_d;
  logic            rr_ptr_q, rr_ptr_d;
  logic [FP_W-1:0] fa_q, fb_q;
  logic            db_q, tag_q;
  unpk_res_t       res_a_q, res_b_q;
  unpk_res_t       unit_res;
  logic [FP_W:0]   unit_op;
  logic            win;
  logic [1:0]      gnt;
  logic            gnt_idx;
  logic            grant;
  logic [FP_W-1:0] sel_fa, sel_fb;
  logic            sel_db;

  // Reset also closes the window so no ready escapes while rst_n is low.
  assign win = rst_n & ((state_q == IDLE) | ((state_q == OUT) & out_ready));

  unpack_rr_arb u_arb (
    .en_i  (win),
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign grant     = |gnt;
  assign req_ready = gnt;
  assign sel_fa    = gnt_idx ? req_fa[2*FP_W-1:FP_W] : req_fa[FP_W-1:0];
  assign sel_fb    = gnt_idx ? req_fb[2*FP_W-1:FP_W] : req_fb[FP_W-1:0];
  assign sel_db    = req_db[gnt_idx];

  exponent u_exponent (
    .op_i  (unit_op),
    .res_o (unit_res)
  );

  // Next state, round-robin pointer and shared-unit operand mux.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    unit_op  = '0;
    case (state_q)
      IDLE: begin
        if (grant) state_d = UNPK_A;
      end
      UNPK_A: begin
        unit_op = {fa_q, db_q};
        state_d = UNPK_B;
      end
      UNPK_B: begin
        unit_op = {fb_q, db_q};
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) state_d = grant ? UNPK_A : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (grant) rr_ptr_d = ~gnt_idx;
  end

  // State and arbitration pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= RR_RESET;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Capture the granted operand pair, precision and tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fa_q  <= '0;
      fb_q  <= '0;
      db_q  <= 1'b0;
      tag_q <= 1'b0;
    end else if (grant) begin
      fa_q  <= sel_fa;
      fb_q  <= sel_fb;
      db_q  <= sel_db;
      tag_q <= gnt_idx;
    end
  end

  // Latch shared-unit results into the A and B halves of the bundle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_a_q <= '0;
      res_b_q <= '0;
    end else begin
      if (state_q == UNPK_A) res_a_q <= unit_res;
      if (state_q == UNPK_B) res_b_q <= unit_res;
    end
  end

  assign out_valid  = (state_q == OUT);
  assign out_tag    = tag_q;
  assign out_db     = db_q;
  assign out_sa     = res_a_q.s;
  assign out_ea     = res_a_q.e;
  assign out_ea_z   = res_a_q.e_z;
  assign out_ea_inf = res_a_q.e_inf;
  assign out_sb     = res_b_q.s;
  assign out_eb     = res_b_q.e;
  assign out_eb_z   = res_b_q.e_z;
  assign out_eb_inf = res_b_q.e_inf;

`ifdef FPU_UNPACK_STATS_EN
  logic [STAT_W-1:0] stat_q, stat_d;
  logic              stat_hit;

  assign stat_hit = ((state_q == UNPK_A) | (state_q == UNPK_B)) &
                    (unit_res.e_z | unit_res.e_inf);

  // Saturating special-operand count; clear wins over increment.
  always_comb begin
    stat_d = stat_q;
    if (stat_clr) begin
      stat_d = '0;
    end else if (stat_hit && !(&stat_q)) begin
      stat_d = stat_q + STAT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat_q <= '0;
    else        stat_q <= stat_d;
  end

  assign stat_special = stat_q;
`else
  logic [STAT_W-1:0] unused_stat_w;
  assign unused_stat_w = '0;
`endif

endmodule

// File: tb/tb_fpu_unpack_sched.sv
// Directed bench for fpu_unpack_sched; stats scenario built with FPU_UNPACK_STATS_EN.
module tb_fpu_unpack_sched;

`ifdef FPU_UNPACK_STATS_EN
  localparam int SW = 2;
`else
  localparam int SW = 16;
`endif

  logic         clk;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [127:0] req_fa;
  logic [127:0] req_fb;
  logic [1:0]   req_db;
  logic         out_valid;
  logic         out_ready;
  logic         out_tag, out_db, out_sa, out_sb;
  logic [10:0]  out_ea, out_eb;
  logic         out_ea_z, out_eb_z, out_ea_inf, out_eb_inf;
`ifdef FPU_UNPACK_STATS_EN
  logic          stat_clr;
  logic [SW-1:0] stat_special;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fpu_unpack_sched #(
    .STAT_W   (SW),
    .RR_RESET (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_fa     (req_fa),
    .req_fb     (req_fb),
    .req_db     (req_db),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_tag    (out_tag),
    .out_db     (out_db),
    .out_sa     (out_sa),
    .out_sb     (out_sb),
    .out_ea     (out_ea),
    .out_eb     (out_eb),
    .out_ea_z   (out_ea_z),
    .out_eb_z   (out_eb_z),
    .out_ea_inf (out_ea_inf),
    .out_eb_inf (out_eb_inf)
`ifdef FPU_UNPACK_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat_special (stat_special)
`endif
  );

  function automatic logic [30:0] obs();
    return {out_valid, out_tag, out_db, out_sa, out_ea, out_ea_z, out_ea_inf,
            out_sb, out_eb, out_eb_z, out_eb_inf};
  endfunction

  function automatic logic [30:0] bundle(input logic v, input logic t, input logic d,
                                         input logic sa, input logic [10:0] ea,
                                         input logic eaz, input logic eai,
                                         input logic sb, input logic [10:0] eb,
                                         input logic ebz, input logic ebi);
    return {v, t, d, sa, ea, eaz, eai, sb, eb, ebz, ebi};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    out_ready = 1'b0;
`ifdef FPU_UNPACK_STATS_EN
    stat_clr  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_fa    = '0;
    req_fb    = '0;
    req_db    = 2'b00;
    out_ready = 1'b1;
`ifdef FPU_UNPACK_STATS_EN
    stat_clr  = 1'b0;
`endif
    #3;
    n_checks++;
    if (obs() !== 31'h0) $display("FAIL reset_bundle: got %h expected %h", obs(), 31'h0);
    else n_pass++;
    n_checks++;
    if (req_ready !== 2'b00) $display("FAIL reset_ready: got %b expected 00", req_ready);
    else n_pass++;
`ifdef FPU_UNPACK_STATS_EN
    n_checks++;
    if (stat_special !== '0) $display("FAIL reset_stat: got %0d expected 0", stat_special);
    else n_pass++;
`endif
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_release_valid: got %b expected 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_req0_double();
    logic [30:0] exp_b;
    exp_b     = bundle(1'b1, 1'b0, 1'b1, 1'b0, 11'h000, 1'b0, 1'b0,
                       1'b1, 11'h400, 1'b0, 1'b1);
    req_fa    = {64'h0, 64'h3FF0_0000_0000_0000};
    req_fb    = {64'h0, 64'hFFF0_0000_0000_0000};
    req_db    = 2'b01;
    req_valid = 2'b01;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) $display("FAIL d0_grant: got %b expected 01", req_ready);
    else n_pass++;
    step();
    req_valid = 2'b00;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL d0_latency_t1: got %b expected 0", out_valid);
    else n_pass++;
    step();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL d0_latency_t2: got %b expected 0", out_valid);
    else n_pass++;
    step();
    n_checks++;
    if (obs() !== exp_b) $display("FAIL d0_bundle: got %h expected %h", obs(), exp_b);
    else n_pass++;
    step();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL d0_drain: got %b expected 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_req1_single();
    logic [30:0] exp_b;
    exp_b     = bundle(1'b1, 1'b1, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0,
                       1'b0, 11'h002, 1'b1, 1'b0);
    req_fa    = {32'h3F80_0000, 32'h0, 64'h0};
    req_fb    = '0;
    req_db    = 2'b00;
    req_valid = 2'b10;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 2'b10) $display("FAIL s1_grant: got %b expected 10", req_ready);
    else n_pass++;
    step();
    req_valid = 2'b00;
    step();
    step();
    n_checks++;
    if (obs() !== exp_b) $display("FAIL s1_bundle: got %h expected %h", obs(), exp_b);
    else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [30:0] exp0, exp1, exp_b;
    logic [1:0]  exp_rdy;
    exp0 = bundle(1'b1, 1'b0, 1'b1, 1'b0, 11'h001, 1'b0, 1'b0,
                  1'b0, 11'h7FF, 1'b0, 1'b0);
    exp1 = bundle(1'b1, 1'b1, 1'b0, 1'b0, 11'h003, 1'b0, 1'b0,
                  1'b0, 11'h080, 1'b0, 1'b1);
    do_reset();
    req_fa    = {32'h4100_0000, 32'h0, 64'h4000_0000_0000_0000};
    req_fb    = {32'h7F80_0000, 32'h0, 64'h3FE0_0000_0000_0000};
    req_db    = 2'b01;
    req_valid = 2'b11;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) $display("FAIL b2b_first_grant: got %b expected 01", req_ready);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL b2b_unpk_valid k=%0d: got %b expected 0", k, out_valid);
      else n_pass++;
      step();
      step();
      if (k == 3) req_valid = 2'b00;
      #1;
      exp_b   = (k % 2 == 0) ? exp0 : exp1;
      exp_rdy = (k == 3) ? 2'b00 : ((k % 2 == 0) ? 2'b10 : 2'b01);
      n_checks++;
      if (obs() !== exp_b) $display("FAIL b2b_bundle k=%0d: got %h expected %h", k, obs(), exp_b);
      else n_pass++;
      n_checks++;
      if (req_ready !== exp_rdy) $display("FAIL b2b_ready k=%0d: got %b expected %b", k, req_ready, exp_rdy);
      else n_pass++;
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [30:0] exp0, exp1;
    exp0 = bundle(1'b1, 1'b0, 1'b1, 1'b0, 11'h000, 1'b0, 1'b0,
                  1'b1, 11'h400, 1'b0, 1'b1);
    exp1 = bundle(1'b1, 1'b1, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0,
                  1'b0, 11'h002, 1'b1, 1'b0);
    req_fa    = {32'h3F80_0000, 32'h0, 64'h3FF0_0000_0000_0000};
    req_fb    = {64'h0, 64'hFFF0_0000_0000_0000};
    req_db    = 2'b01;
    req_valid = 2'b01;
    out_ready = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) $display("FAIL bp_idle_grant: got %b expected 01", req_ready);
    else n_pass++;
    step();
    req_valid = 2'b10;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({obs(), req_ready} !== {exp0, 2'b00})
        $display("FAIL bp_hold i=%0d: got %h/%b expected %h/00", i, obs(), req_ready, exp0);
      else n_pass++;
      step();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 2'b10) $display("FAIL bp_release_grant: got %b expected 10", req_ready);
    else n_pass++;
    step();
    req_valid = 2'b00;
    step();
    step();
    n_checks++;
    if (obs() !== exp1) $display("FAIL bp_second_bundle: got %h expected %h", obs(), exp1);
    else n_pass++;
    step();
  endtask

  task automatic test_reset_midop();
    logic bad;
    req_fa    = {64'h0, 64'h4020_0000_0000_0000};
    req_fb    = {64'h0, 64'h4020_0000_0000_0000};
    req_db    = 2'b01;
    req_valid = 2'b01;
    out_ready = 1'b1;
    step();
    req_valid = 2'b00;
    step();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, req_ready} !== 3'b000)
      $display("FAIL rst_unpkb_outputs: got %b/%b expected 0/00", out_valid, req_ready);
    else n_pass++;
    n_checks++;
    if (obs() !== 31'h0) $display("FAIL rst_unpkb_data: got %h expected %h", obs(), 31'h0);
    else n_pass++;
    @(posedge clk);
    #2 rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid !== 1'b0 || req_ready !== 2'b00) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) $display("FAIL rst_no_stale: got %b expected 0", bad);
    else n_pass++;
    req_valid = 2'b01;
    out_ready = 1'b0;
    step();
    req_valid = 2'b00;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL rst_out_async: got %b expected 0", out_valid);
    else n_pass++;
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
  endtask

`ifdef FPU_UNPACK_STATS_EN
  task automatic test_stats();
    do_reset();
    req_fa    = '0;
    req_fb    = '0;
    req_db    = 2'b00;
    out_ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      step();
      step();
      if (p == 0) begin
        n_checks++;
        if (stat_special !== 2'd2) $display("FAIL stat_first_pair: got %0d expected 2", stat_special);
        else n_pass++;
      end
      step();
    end
    n_checks++;
    if (stat_special !== 2'd3) $display("FAIL stat_saturate: got %0d expected 3", stat_special);
    else n_pass++;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    stat_clr  = 1'b1;
    step();
    stat_clr  = 1'b0;
    n_checks++;
    if (stat_special !== 2'd0) $display("FAIL stat_clr_priority: got %0d expected 0", stat_special);
    else n_pass++;
    step();
    n_checks++;
    if (stat_special !== 2'd1) $display("FAIL stat_after_clr: got %0d expected 1", stat_special);
    else n_pass++;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_req0_double();
    test_req1_single();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
`ifdef FPU_UNPACK_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
